// File: rtl/uvmt_cv32e40x_obi_mem_arbiter_if.sv
// uvmt_cv32e40x_obi_mem_arbiter_if: two requester OBI ports plus the shared memory port.
// slave is the arbiter's view, master is the view of whoever drives the requesters and memory.
interface uvmt_cv32e40x_obi_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]                       s_req_i;
    logic [1:0]                       s_gnt_o;
    logic [1:0][ADDR_WIDTH-1:0]       s_addr_i;
    logic [1:0]                       s_we_i;
    logic [1:0][DATA_WIDTH/8-1:0]     s_be_i;
    logic [1:0][DATA_WIDTH-1:0]       s_wdata_i;
    logic [1:0]                       s_rvalid_o;
    logic [DATA_WIDTH-1:0]            s_rdata_o;
    logic                             s_err_o;
    logic                             m_req_o;
    logic                             m_gnt_i;
    logic [ADDR_WIDTH-1:0]            m_addr_o;
    logic                             m_we_o;
    logic [DATA_WIDTH/8-1:0]          m_be_o;
    logic [DATA_WIDTH-1:0]            m_wdata_o;
    logic                             m_rvalid_i;
    logic [DATA_WIDTH-1:0]            m_rdata_i;
    logic                             m_err_i;

    modport slave (
        input  s_req_i, s_addr_i, s_we_i, s_be_i, s_wdata_i, m_gnt_i, m_rvalid_i, m_rdata_i, m_err_i,
        output s_gnt_o, s_rvalid_o, s_rdata_o, s_err_o, m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o
    );

    modport master (
        output s_req_i, s_addr_i, s_we_i, s_be_i, s_wdata_i, m_gnt_i, m_rvalid_i, m_rdata_i, m_err_i,
        input  s_gnt_o, s_rvalid_o, s_rdata_o, s_err_o, m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o
    );
endinterface

// File: rtl/uvmt_cv32e40x_obi_mem_arbiter.sv
// uvmt_cv32e40x_obi_mem_arbiter: round-robin OBI arbiter (instr=0, data=1) onto one memory port,
// with request locking until grant and an in-order ID FIFO routing responses back.
module uvmt_cv32e40x_obi_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    uvmt_cv32e40x_obi_mem_arbiter_if.slave     bus,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               protocol_err_o
);
    localparam int AW = $clog2(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, LOCKED_I, LOCKED_D} state_t;

    state_t                   state_q, state_d;
    logic                     rr_q, rr_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [AW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]              count_q, count_d;
    logic                     perr_q, perr_d;
    logic                     sel, full, req, hs, pop;
    logic [ADDR_WIDTH-1:0]    addr_sel;
    logic [DATA_WIDTH-1:0]    wdata_sel;

    always_comb begin
        sel = state_q == LOCKED_I ? 1'b0 :
              state_q == LOCKED_D ? 1'b1 :
              bus.s_req_i == 2'b01 ? 1'b0 :
              bus.s_req_i == 2'b10 ? 1'b1 : rr_q;
        // full uses the registered count so a response never combinationally releases a request
        full = count_q == (AW+1)'(MAX_OUTSTANDING);
        req = bus.s_req_i[sel] && !full;
        hs = req && bus.m_gnt_i;
        pop = bus.m_rvalid_i && count_q != '0;
        addr_sel = req ? bus.s_addr_i[sel] : '0;
        wdata_sel = req ? bus.s_wdata_i[sel] : '0;
        bus.m_req_o = req;
        bus.m_addr_o = addr_sel;
        bus.m_we_o = req && bus.s_we_i[sel];
        bus.m_be_o = req ? bus.s_be_i[sel] : '0;
        bus.m_wdata_o = wdata_sel;
        bus.s_gnt_o = hs ? (sel ? 2'b10 : 2'b01) : 2'b00;
        bus.s_rvalid_o = pop ? (fifo_q[rptr_q] ? 2'b10 : 2'b01) : 2'b00;
        bus.s_rdata_o = bus.m_rdata_i;
        bus.s_err_o = bus.m_err_i;
        // stay locked while the frozen requester keeps req high, even when gated by full
        state_d = hs ? IDLE :
                  (req || (state_q != IDLE && bus.s_req_i[sel])) ? (sel ? LOCKED_D : LOCKED_I) : IDLE;
        rr_d = hs ? ~sel : rr_q;
        fifo_d = fifo_q;
        if (hs) fifo_d[wptr_q] = sel;
        wptr_d = wptr_q + AW'(hs);
        rptr_d = rptr_q + AW'(pop);
        count_d = count_q + (AW+1)'(hs) - (AW+1)'(pop);
        perr_d = perr_q || (bus.m_rvalid_i && count_q == '0);
        outstanding_o = count_q;
        protocol_err_o = perr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            fifo_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            fifo_q  <= fifo_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            perr_q  <= perr_d;
        end
    end
endmodule

// File: tb/tb_uvmt_cv32e40x_obi_mem_arbiter.sv
// tb_uvmt_cv32e40x_obi_mem_arbiter: directed bench; expected response routing is queued at
// grant time and popped when the memory returns rvalid.
module tb_uvmt_cv32e40x_obi_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] outstanding;
    logic       perr;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [1:0] sb[$];

    always #5 clk = ~clk;

    uvmt_cv32e40x_obi_mem_arbiter_if bus ();

    uvmt_cv32e40x_obi_mem_arbiter dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus            (bus),
        .outstanding_o  (outstanding),
        .protocol_err_o (perr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        bus.s_req_i = req;
        bus.m_gnt_i = gnt;
        bus.m_rvalid_i = rv;
        bus.m_rdata_i = rd;
        #2;
    endtask

    task automatic chk_rv(input string tag);
        chk(tag, 64'(bus.s_rvalid_o), sb.size() != 0 ? 64'(sb.pop_front()) : 64'h3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.s_req_i = '0;
        bus.m_gnt_i = 1'b0;
        bus.m_rvalid_i = 1'b0;
        #1;
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_perr", 64'(perr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.s_req_i = '0;
        bus.s_addr_i[0] = 32'h0000_0080;
        bus.s_addr_i[1] = 32'h0000_1000;
        bus.s_we_i = 2'b00;
        bus.s_be_i[0] = 4'hF;
        bus.s_be_i[1] = 4'h3;
        bus.s_wdata_i[0] = '0;
        bus.s_wdata_i[1] = 32'hCAFE_F00D;
        bus.m_gnt_i = 1'b0;
        bus.m_rvalid_i = 1'b0;
        bus.m_rdata_i = '0;
        bus.m_err_i = 1'b0;
        do_reset();
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("idle_m_req", 64'(bus.m_req_o), 64'd0);
        chk("idle_m_addr", 64'(bus.m_addr_o), 64'd0);
        chk("idle_s_gnt", 64'(bus.s_gnt_o), 64'd0);
        chk("idle_s_rvalid", 64'(bus.s_rvalid_o), 64'd0);
        // single instruction fetch
        step(2'b01, 1'b1, 1'b0, 32'h0);
        chk("t1_m_req", 64'(bus.m_req_o), 64'd1);
        chk("t1_m_addr", 64'(bus.m_addr_o), 64'h80);
        chk("t1_s_gnt", 64'(bus.s_gnt_o), 64'h1);
        sb.push_back(2'b01);
        step(2'b00, 1'b0, 1'b1, 32'h0000_0013);
        chk("t1_outstanding", 64'(outstanding), 64'd1);
        chk_rv("t1_rvalid");
        chk("t1_rdata", 64'(bus.s_rdata_o), 64'h13);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t1_outstanding_end", 64'(outstanding), 64'd0);
        // both requesting: alternate starting with instr, then fill to MAX_OUTSTANDING
        do_reset();
        step(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t2_gnt0", 64'(bus.s_gnt_o), 64'h1);
        sb.push_back(2'b01);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t2_gnt1", 64'(bus.s_gnt_o), 64'h2);
        chk("t2_addr1", 64'(bus.m_addr_o), 64'h1000);
        sb.push_back(2'b10);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t2_gnt2", 64'(bus.s_gnt_o), 64'h1);
        sb.push_back(2'b01);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t2_gnt3", 64'(bus.s_gnt_o), 64'h2);
        sb.push_back(2'b10);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t2_full_m_req", 64'(bus.m_req_o), 64'd0);
        chk("t2_full_s_gnt", 64'(bus.s_gnt_o), 64'd0);
        chk("t2_full_outstanding", 64'(outstanding), 64'd4);
        step(2'b11, 1'b1, 1'b1, 32'h11);
        chk("t2_pop_no_unblock", 64'(bus.m_req_o), 64'd0);
        chk_rv("t2_rv0");
        step(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t2_unblock_m_req", 64'(bus.m_req_o), 64'd1);
        chk("t2_unblock_gnt", 64'(bus.s_gnt_o), 64'h1);
        sb.push_back(2'b01);
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 1'b0, 1'b1, 32'h20 + 32'(i));
            chk_rv($sformatf("t2_drain%0d", i));
        end
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t2_outstanding_end", 64'(outstanding), 64'd0);
        // data write held without grant while instr joins: address must stay frozen
        bus.s_we_i = 2'b10;
        step(2'b10, 1'b0, 1'b0, 32'h0);
        chk("t3_addr_c0", 64'(bus.m_addr_o), 64'h1000);
        chk("t3_we", 64'(bus.m_we_o), 64'd1);
        chk("t3_be", 64'(bus.m_be_o), 64'h3);
        chk("t3_wdata", 64'(bus.m_wdata_o), 64'hCAFE_F00D);
        step(2'b11, 1'b0, 1'b0, 32'h0);
        chk("t3_addr_c1", 64'(bus.m_addr_o), 64'h1000);
        chk("t3_gnt_c1", 64'(bus.s_gnt_o), 64'h0);
        step(2'b11, 1'b0, 1'b0, 32'h0);
        chk("t3_addr_c2", 64'(bus.m_addr_o), 64'h1000);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t3_gnt_data", 64'(bus.s_gnt_o), 64'h2);
        sb.push_back(2'b10);
        step(2'b01, 1'b1, 1'b0, 32'h0);
        chk("t3_gnt_instr", 64'(bus.s_gnt_o), 64'h1);
        chk("t3_instr_we", 64'(bus.m_we_o), 64'd0);
        sb.push_back(2'b01);
        bus.m_err_i = 1'b1;
        step(2'b00, 1'b0, 1'b1, 32'h0);
        chk_rv("t3_rv_data");
        chk("t3_err", 64'(bus.s_err_o), 64'd1);
        bus.m_err_i = 1'b0;
        step(2'b00, 1'b0, 1'b1, 32'h0);
        chk_rv("t3_rv_instr");
        chk("t3_err_clear", 64'(bus.s_err_o), 64'd0);
        // simultaneous push and pop at occupancy 2
        step(2'b01, 1'b1, 1'b0, 32'h0);
        sb.push_back(2'b01);
        step(2'b01, 1'b1, 1'b0, 32'h0);
        sb.push_back(2'b01);
        step(2'b10, 1'b1, 1'b1, 32'h0);
        chk("t4_outstanding_pre", 64'(outstanding), 64'd2);
        chk("t4_gnt", 64'(bus.s_gnt_o), 64'h2);
        chk_rv("t4_rv_oldest");
        sb.push_back(2'b10);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t4_outstanding_post", 64'(outstanding), 64'd2);
        step(2'b00, 1'b0, 1'b1, 32'h0);
        chk_rv("t4_drain0");
        step(2'b00, 1'b0, 1'b1, 32'h0);
        chk_rv("t4_drain1");
        // requester drops req while locked: no push, back to open selection
        step(2'b01, 1'b0, 1'b0, 32'h0);
        chk("t5_locked_req", 64'(bus.m_req_o), 64'd1);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t5_drop_m_req", 64'(bus.m_req_o), 64'd0);
        chk("t5_no_push", 64'(outstanding), 64'd0);
        step(2'b10, 1'b1, 1'b0, 32'h0);
        chk("t5_gnt_data", 64'(bus.s_gnt_o), 64'h2);
        sb.push_back(2'b10);
        step(2'b00, 1'b0, 1'b1, 32'h0);
        chk_rv("t5_rv");
        // rvalid on empty FIFO: dropped, sticky protocol error until reset
        step(2'b00, 1'b0, 1'b1, 32'h0);
        chk("t6_outstanding", 64'(outstanding), 64'd0);
        chk("t6_rvalid_none", 64'(bus.s_rvalid_o), 64'h0);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t6_perr_set", 64'(perr), 64'd1);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t6_perr_sticky", 64'(perr), 64'd1);
        do_reset();
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
